// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with an
// unsigned or two's-complement mode selected per operation.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] result;
  logic               last;

  // Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which still fits unsigned in WIDTH bits.
  always_comb begin
    a_mag   = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    b_mag   = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
    acc_sum = mplier[0] ? (acc + mcand) : acc;
    result  = (neg && (acc_sum != '0)) ? (~acc_sum + (2*WIDTH)'(1)) : acc_sum;
    last    = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand  <= {{WIDTH{1'b0}}, a_mag};
            mplier <= b_mag;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt    <= '0;
            acc    <= '0;
            state  <= RUN;
            busy   <= 1'b1;
            done   <= 1'b0;
          end else begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
          end
        end
        RUN: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            product <= result;
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed-vector bench for seq_shift_add_multiplier at WIDTH=8.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  seq_shift_add_multiplier #(.WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .product     (product),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Launch one operation, scramble operands while busy, then check result,
  // busy length and that done is a single pulse.
  task automatic run_op(input string tag, input logic sm, input logic [7:0] va,
                        input logic [7:0] vb, input logic [15:0] exp);
    int unsigned cycles;
    @(negedge clk);
    start = 1'b1; signed_mode = sm; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < 20) begin
      cycles++;
      a = 8'($urandom); b = 8'($urandom); signed_mode = ~sm;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, cycles, 8);
    check({tag, "_done"}, {31'd0, done}, 1);
    check({tag, "_product"}, {16'd0, product}, {16'd0, exp});
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done}, 0);
  endtask

  initial begin
    int unsigned done_cnt;
    int unsigned t1;
    int unsigned t2;
    logic [15:0] p1;
    logic [15:0] p2;

    reset = 1'b1; start = 1'b1; signed_mode = 1'b0; a = 8'd3; b = 8'd3;
    #1;
    check("reset_product", {16'd0, product}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("start_during_reset_ignored", {31'd0, busy}, 0);

    run_op("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01);
    run_op("s_fd_05", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
    run_op("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000);
    run_op("s_00_80", 1'b1, 8'h00, 8'h80, 16'h0000);
    run_op("u_00_ff", 1'b0, 8'h00, 8'hFF, 16'h0000);
    run_op("s_7f_80", 1'b1, 8'h7F, 8'h80, 16'hC080);
    run_op("u_80_80", 1'b0, 8'h80, 8'h80, 16'h4000);

    // Restart attempt during RUN must be ignored.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a = 8'd7; b = 8'd6;
    done_cnt = 0; p1 = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      start = (i == 3);
      a = (i == 3) ? 8'd1 : 8'($urandom);
      b = (i == 3) ? 8'd1 : 8'($urandom);
      if (done) begin done_cnt++; p1 = product; end
    end
    start = 1'b0;
    check("restart_done_count", done_cnt, 1);
    check("restart_product", {16'd0, p1}, 42);
    check("restart_final_product", {16'd0, product}, 42);

    // Back-to-back with start held high.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a = 8'd3; b = 8'd4;
    t1 = 0; t2 = 0; p1 = '0; p2 = '0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done && t1 == 0) begin
        t1 = i; p1 = product; a = 8'd5; b = 8'd6;
      end else if (done && t2 == 0) begin
        t2 = i; p2 = product; start = 1'b0; a = 8'd0; b = 8'd0;
      end
    end
    start = 1'b0;
    check("b2b_first_time", t1, 9);
    check("b2b_first_product", {16'd0, p1}, 12);
    check("b2b_gap", t2 - t1, 9);
    check("b2b_second_product", {16'd0, p2}, 30);

    // Reset mid-operation aborts it.
    run_op("u_07_06", 1'b0, 8'd7, 8'd6, 16'd42);
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; a = 8'd9; b = 8'd9;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("abort_busy_before", {31'd0, busy}, 1);
    reset = 1'b1;
    #1;
    check("abort_product", {16'd0, product}, 0);
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    check("abort_product_held", {16'd0, product}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_shift_add_multiplier.md
SEQ_SHIFT_ADD_MULTIPLIER -- requirements
Module: seq_shift_add_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new multiplication; sampled on rising clk.
REQ-005 signed_mode  input  1  1 = operands two's-complement, 0 = unsigned; sampled with start.
REQ-006 a  input  WIDTH  multiplicand; sampled with start.
REQ-007 b  input  WIDTH  multiplier; sampled with start.
REQ-008 product  output  2*WIDTH  registered result of the most recent completed operation.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle pulse marking product update.

Function
REQ-011 FSM states SHALL be IDLE, RUN, DONE; busy = (state == RUN); done = (state == DONE).
REQ-012 Start SHALL be accepted when start=1 and state is IDLE or DONE; a, b, signed_mode captured at that edge, bit counter cleared, accumulator cleared, state -> RUN.
REQ-013 start=1 while state == RUN SHALL be ignored; captured operands and progress unaffected.
REQ-014 In RUN, each edge SHALL process one multiplier bit LSB-first: if the current bit is 1, add the shifted multiplicand magnitude into the 2*WIDTH accumulator; then shift and increment the counter.
REQ-015 After exactly WIDTH RUN edges, state SHALL -> DONE and product SHALL be loaded on that same edge.
REQ-016 Latency: start accepted at edge k -> busy high cycles following edges k..k+WIDTH-1 -> product valid and done high in the cycle after edge k+WIDTH; fixed, independent of operand values.
REQ-017 From DONE, state SHALL go to IDLE on the next edge unless a new start is accepted (REQ-012), giving back-to-back throughput of one result per WIDTH+1 cycles.
REQ-018 Unsigned mode: product = a * b, zero-extended, exact in 2*WIDTH bits.
REQ-019 Signed mode: operands converted to magnitudes at capture; result sign = sign(a) XOR sign(b); negative result two's-complement-negated before load; exact in 2*WIDTH bits.
REQ-020 Signed most-negative operands: magnitude 2^(WIDTH-1) SHALL be handled correctly (-2^(WIDTH-1) * -2^(WIDTH-1) = +2^(2*WIDTH-2)).
REQ-021 A zero result SHALL never carry a negative sign (signed 0 * negative = 0).
REQ-022 product SHALL hold its value between completions; it changes only on the DONE-entry edge and on reset.
REQ-023 Input changes on a, b, signed_mode while busy SHALL not affect the in-flight result.

Reset
REQ-024 reset=1 SHALL asynchronously force state IDLE, product = 0, busy = 0, done = 0, counter, accumulator and captured operands = 0.
REQ-025 Reset asserted mid-operation SHALL abort it; no done pulse and no product update follow reset deassertion.
REQ-026 start=1 during reset SHALL be ignored; first acceptance is the first rising edge with reset=0.

Verification
REQ-027 WIDTH=8, unsigned, a=255, b=255, start one cycle -> busy 8 cycles, done pulse once, product = 0xFE01.
REQ-028 WIDTH=8, signed, a=0xFD (-3), b=0x05 -> product = 0xFFF1 (-15); a=0x80, b=0x80 -> product = 0x4000.
REQ-029 WIDTH=8, signed, a=0x00, b=0x80 -> product = 0x0000; unsigned a=0x00, b=0xFF -> product = 0x0000, latency still 8 cycles.
REQ-030 Start a=7, b=6, pulse start again with a=1, b=1 at RUN cycle 3, change a/b every cycle -> single done, product = 42, second start ignored.
REQ-031 Back-to-back: start held high continuously with a=3, b=4 then a=5, b=6 presented at each DONE cycle -> done every 9 cycles, products 12 then 30.
REQ-032 Reset asserted at RUN cycle 4 of a=9, b=9 (previous product 42) -> product = 0, busy = 0 immediately, no done after release.
